buffer_row_summer: RTL and testbench
====================================

# buffer_row_summer

Drain-and-reduce stage downstream of the io_buffer stack in the matrix_ops datapath. On a start command it issues pop commands to the buffer and consumes the popped words. It accumulates each group of ROW_LEN consecutive words into a row sum, and presents each sum on a valid/ready output, NUM_ROWS times per start. Element order is buffer pop order (LIFO).

## Interface
- DATA_WIDTH, 16, width of one buffer element (matches the buffer's DATA_WIDTH)
- ROW_LEN, 4, elements per row sum (≥2)
- NUM_ROWS, 4, rows per start command (≥1)
- SUM_WIDTH (localparam), DATA_WIDTH + clog2(ROW_LEN), overflow-free sum width
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  single-cycle request to drain NUM_ROWS×ROW_LEN elements
- o_busy  out  1  high from the cycle after an accepted i_start until the cycle o_done pulses
- o_pop_cmd  out  1  drives the buffer's i_pop_cmd
- i_buf_data  in  DATA_WIDTH  the buffer's o_data; valid the cycle after o_pop_cmd
- o_sum  out  SUM_WIDTH  row sum, stable while o_sum_valid
- o_sum_valid  out  1  row sum available
- i_sum_ready  in  1  consumer accepts o_sum
- o_row_idx  out  clog2(NUM_ROWS) (min 1)  index of the row currently in o_sum, 0-based
- o_done  out  1  one-cycle pulse after the last row is accepted

## Operation
- FSM states: IDLE, POP, FLUSH, OUT.
- **IDLE**
  - i_start → POP. Clear the column counter and the row counter.
  - i_start is ignored in every other state.
- **POP**
  - o_pop_cmd = 1 every cycle. The column counter increments.
  - After ROW_LEN pops → FLUSH.
- **Accumulation**
  - Each cycle following a pop, capture i_buf_data.
  - The first element of a row loads the accumulator; later elements add to it.
- **FLUSH**
  - One cycle. Captures the final element; no pop.
  - → OUT with o_sum = accumulator.
- **OUT**
  - o_sum_valid = 1, held with o_sum stable until i_sum_ready.
  - On handshake, if the row counter = NUM_ROWS−1: → IDLE and pulse o_done. Otherwise: increment the row counter → POP.
- **Arithmetic**
  - Operands are zero-extended to SUM_WIDTH.
  - The sum cannot overflow: SUM_WIDTH covers ROW_LEN×(2^DATA_WIDTH−1).
- **Buffer sizing**
  - The block does not track buffer occupancy. The upstream controller must have pushed ≥ NUM_ROWS×ROW_LEN elements before i_start.
  - Underflowing the buffer is not detected; the sums are whatever the buffer returns.
- **Reset values**
  - State IDLE.
  - o_pop_cmd, o_sum_valid, o_done, o_busy = 0.
  - o_sum = 0, o_row_idx = 0.
  - Accumulator and counters = 0.
- **Reset mid-operation:** outputs drop immediately (asynchronous). No partial sum is emitted after reset release.

## Timing
- i_start sampled at edge 0.
  - o_pop_cmd is high in cycles 1..ROW_LEN.
  - Data is captured at edges 2..ROW_LEN+1.
  - o_sum_valid is first high in cycle ROW_LEN+2 (FLUSH is cycle ROW_LEN+1).
- Handshake in cycle N:
  - o_sum_valid is low in N+1.
  - For a non-last row, o_pop_cmd is high in N+1 and o_row_idx has incremented.
  - For the last row, o_done is high in N+1 only, o_busy is low from N+1, and the FSM is in IDLE.
- Per-row cost with i_sum_ready tied high: ROW_LEN+2 cycles.
- A new i_start is accepted in the cycle o_done is high.

## Configuration
- Macro: BUFFER_ROW_SUMMER_SIGNED_EN.
- Defined: operands are two's-complement and are sign-extended to SUM_WIDTH; o_sum is signed.
- Undefined: operands are zero-extended; o_sum is unsigned.

## Structure
- Package matrix_ops_pkg:
  - clog2 constant function
  - FSM state enum typedef
  - the SUM_WIDTH derivation helper
- One sub-module, row_accumulator. It takes load/add enable and operand, and produces the registered SUM_WIDTH sum, including the sign/zero-extension selected by the macro.
- The FSM and counters live in buffer_row_summer.

## Test plan
- Defaults, i_sum_ready=1, buffer model preloaded by pushing 1..16 → sums 58, 42, 26, 10 with o_row_idx 0..3. o_done 1 cycle after the 4th handshake. 16 pops total.
- Check first-row latency: i_start at edge 0 → o_pop_cmd high cycles 1–4 and o_sum_valid first high in cycle 6.
- Backpressure: hold i_sum_ready=0 for 5 cycles on row 1 → o_sum=42 stable, o_pop_cmd low throughout, no extra pops.
- Saturation: row of four 0xFFFF → o_sum=0x3FFFC, no wrap.
- Signedness, row {0xFFFF,1,0,0} → o_sum 0x10000 without the macro, 0x00000 with BUFFER_ROW_SUMMER_SIGNED_EN defined.
- Reset mid-POP: assert i_rst_n low in cycle 3 → o_pop_cmd/o_busy low immediately. After release, IDLE; a fresh i_start yields correct sums. Extra i_start pulses while o_busy are ignored.

Source files
------------

// File: rtl/matrix_ops_pkg.sv
// ---------------------------------------------------------------------------
// matrix_ops_pkg
// Shared types and elaboration-time helpers for the matrix_ops datapath.
//   - state_t   : buffer_row_summer FSM encoding
//   - clog2     : ceiling log2 of a positive integer (clog2(1) = 0)
//   - sum_width : width of an overflow-free sum of row_len elements
//   - idx_width : counter width for n items, never less than one bit
// ---------------------------------------------------------------------------
package matrix_ops_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        FLUSH = 2'd2,
        OUT   = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 32'sd1;
        r = 32'sd0;
        while (v > 32'sd0) begin
            r = r + 32'sd1;
            v = v >>> 32'sd1;
        end
        return r;
    endfunction

    function automatic int sum_width(input int data_width, input int row_len);
        return data_width + clog2(row_len);
    endfunction

    function automatic int idx_width(input int n);
        return (clog2(n) < 32'sd1) ? 32'sd1 : clog2(n);
    endfunction

endpackage

// File: rtl/row_accumulator.sv
// ---------------------------------------------------------------------------
// row_accumulator
// Registered row-sum accumulator. The operand is widened to SUM_WIDTH before
// the add: zero-extended by default, sign-extended when the build defines
// BUFFER_ROW_SUMMER_SIGNED_EN.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : replace the sum with the widened operand (first element)
//   i_add          : add the widened operand to the sum
//   i_operand      : DATA_WIDTH element
//   o_sum          : SUM_WIDTH registered sum
// ---------------------------------------------------------------------------
module row_accumulator
    import matrix_ops_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ROW_LEN    = 4,
    localparam int SUM_WIDTH = sum_width(DATA_WIDTH, ROW_LEN)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic                  i_add,
    input  logic [DATA_WIDTH-1:0] i_operand,
    output logic [SUM_WIDTH-1:0]  o_sum
);

    localparam int EXT_W = SUM_WIDTH - DATA_WIDTH;

    logic [SUM_WIDTH-1:0] operand_ext_s;
    logic [SUM_WIDTH-1:0] sum_r;

    // Widen the operand; two's-complement addition of the widened patterns
    // gives the correct signed result with the same adder.
    always_comb begin
`ifdef BUFFER_ROW_SUMMER_SIGNED_EN
        operand_ext_s = {{EXT_W{i_operand[DATA_WIDTH-1]}}, i_operand};
`else
        operand_ext_s = {{EXT_W{1'b0}}, i_operand};
`endif
    end

    // Sum register: load on the first element of a row, add afterwards.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sum_r <= '0;
        end else if (i_load) begin
            sum_r <= operand_ext_s;
        end else if (i_add) begin
            sum_r <= sum_r + operand_ext_s;
        end else begin
            sum_r <= sum_r;
        end
    end

    assign o_sum = sum_r;

endmodule

// File: rtl/buffer_row_summer.sv
// ---------------------------------------------------------------------------
// buffer_row_summer
// Drains NUM_ROWS x ROW_LEN words from the io_buffer stack (LIFO pop order)
// and presents one row sum per ROW_LEN words on a valid/ready output.
// Build option: BUFFER_ROW_SUMMER_SIGNED_EN selects two's-complement operands.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : single-cycle request, accepted only when idle
//   o_busy         : operation in progress
//   o_pop_cmd      : pop request to the buffer
//   i_buf_data     : buffer output, valid the cycle after o_pop_cmd
//   o_sum          : row sum, stable while o_sum_valid
//   o_sum_valid    : row sum available
//   i_sum_ready    : consumer accepts o_sum
//   o_row_idx      : 0-based index of the row in o_sum
//   o_done         : one-cycle pulse after the last row is accepted
// ---------------------------------------------------------------------------
module buffer_row_summer
    import matrix_ops_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ROW_LEN    = 4,
    parameter int NUM_ROWS   = 4,
    localparam int SUM_WIDTH = sum_width(DATA_WIDTH, ROW_LEN),
    localparam int ROW_IDX_W = idx_width(NUM_ROWS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_pop_cmd,
    input  logic [DATA_WIDTH-1:0] i_buf_data,
    output logic [SUM_WIDTH-1:0]  o_sum,
    output logic                  o_sum_valid,
    input  logic                  i_sum_ready,
    output logic [ROW_IDX_W-1:0]  o_row_idx,
    output logic                  o_done
);

    localparam int COL_W = clog2(ROW_LEN);
    localparam logic [COL_W-1:0]     LAST_COL = COL_W'(ROW_LEN - 1);
    localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(NUM_ROWS - 1);

    state_t                 state_r;
    state_t                 next_state_s;
    logic [COL_W-1:0]       col_r;
    logic [ROW_IDX_W-1:0]   row_r;
    logic                   pop_cmd_r;
    logic                   sum_valid_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   cap_r;      // i_buf_data holds a popped word this cycle
    logic                   first_r;    // that word is the first of its row
    logic                   start_s;
    logic                   row_adv_s;
    logic                   done_s;

    // Next-state logic and handshake decode.
    always_comb begin
        next_state_s = state_r;
        start_s      = 1'b0;
        row_adv_s    = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    next_state_s = POP;
                    start_s      = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            POP: begin
                if (col_r == LAST_COL) begin
                    next_state_s = FLUSH;
                end else begin
                    next_state_s = POP;
                end
            end
            FLUSH: begin
                next_state_s = OUT;
            end
            OUT: begin
                if (i_sum_ready) begin
                    if (row_r == LAST_ROW) begin
                        next_state_s = IDLE;
                        done_s       = 1'b1;
                    end else begin
                        next_state_s = POP;
                        row_adv_s    = 1'b1;
                    end
                end else begin
                    next_state_s = OUT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs (outputs follow next state so
    // they line up with the state they describe).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= IDLE;
            col_r       <= '0;
            row_r       <= '0;
            pop_cmd_r   <= 1'b0;
            sum_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cap_r       <= 1'b0;
            first_r     <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            pop_cmd_r   <= (next_state_s == POP);
            sum_valid_r <= (next_state_s == OUT);
            busy_r      <= (next_state_s != IDLE);
            done_r      <= done_s;
            cap_r       <= pop_cmd_r;
            first_r     <= pop_cmd_r && (col_r == '0);

            if (start_s) begin
                col_r <= '0;
            end else if (state_r == POP) begin
                col_r <= (col_r == LAST_COL) ? '0 : col_r + COL_W'(1);
            end else begin
                col_r <= col_r;
            end

            if (start_s) begin
                row_r <= '0;
            end else if (row_adv_s) begin
                row_r <= row_r + ROW_IDX_W'(1);
            end else begin
                row_r <= row_r;
            end
        end
    end

    row_accumulator #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROW_LEN    (ROW_LEN)
    ) u_acc (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (cap_r & first_r),
        .i_add     (cap_r & ~first_r),
        .i_operand (i_buf_data),
        .o_sum     (o_sum)
    );

    assign o_busy      = busy_r;
    assign o_pop_cmd   = pop_cmd_r;
    assign o_sum_valid = sum_valid_r;
    assign o_row_idx   = row_r;
    assign o_done      = done_r;

endmodule

// File: tb/tb_buffer_row_summer.sv
// ---------------------------------------------------------------------------
// tb_buffer_row_summer
// Directed bench for buffer_row_summer with a small LIFO buffer model.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_buffer_row_summer;

    localparam int DW  = 16;
    localparam int RL  = 4;
    localparam int NR  = 4;
    localparam int SW  = 18;
    localparam int RIW = 2;

`ifdef BUFFER_ROW_SUMMER_SIGNED_EN
    localparam logic [31:0] SGN_EXP = 32'h0000_0000;
`else
    localparam logic [31:0] SGN_EXP = 32'h0001_0000;
`endif

    logic           i_clk = 1'b0;
    logic           i_rst_n = 1'b0;
    logic           i_start = 1'b0;
    logic           o_busy;
    logic           o_pop_cmd;
    logic [DW-1:0]  i_buf_data = '0;
    logic [SW-1:0]  o_sum;
    logic           o_sum_valid;
    logic           i_sum_ready = 1'b1;
    logic [RIW-1:0] o_row_idx;
    logic           o_done;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    buffer_row_summer #(
        .DATA_WIDTH (DW),
        .ROW_LEN    (RL),
        .NUM_ROWS   (NR)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .o_busy      (o_busy),
        .o_pop_cmd   (o_pop_cmd),
        .i_buf_data  (i_buf_data),
        .o_sum       (o_sum),
        .o_sum_valid (o_sum_valid),
        .i_sum_ready (i_sum_ready),
        .o_row_idx   (o_row_idx),
        .o_done      (o_done)
    );

    // LIFO buffer model: data appears the cycle after a pop command.
    logic [DW-1:0] mem [0:63];
    int            sp = 0;
    int            pops = 0;
    logic          push_en = 1'b0;
    logic [DW-1:0] push_d = '0;
    logic          buf_clr = 1'b0;

    always @(posedge i_clk) begin
        if (buf_clr) begin
            sp <= 0;
        end else if (push_en) begin
            mem[sp] <= push_d;
            sp      <= sp + 1;
        end else if (o_pop_cmd) begin
            pops <= pops + 1;
            if (sp > 0) begin
                i_buf_data <= mem[sp-1];
                sp         <= sp - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        push_en = 1'b1;
        push_d  = v;
        @(negedge i_clk);
        push_en = 1'b0;
    endtask

    task automatic push_seq_1_16();
        for (int i = 1; i <= 16; i++) push(DW'(i));
    endtask

    task automatic clear_buf();
        buf_clr = 1'b1;
        @(negedge i_clk);
        buf_clr = 1'b0;
    endtask

    // Run one start command; exp[r] is the expected sum of row r.
    // bp_row selects a row held under 5 cycles of backpressure (-1: none).
    task automatic run_rows(input logic [3:0][31:0] exp, input int bp_row);
        int cyc;
        int pops0;
        int hold;
        pops0   = pops;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int r = 0; r < NR; r++) begin
            cyc = 1;
            while (!o_sum_valid && cyc < 40) begin
                check("pop_window", {31'd0, o_pop_cmd}, {31'd0, (cyc <= RL)});
                @(negedge i_clk);
                cyc++;
            end
            check("valid_seen", {31'd0, o_sum_valid}, 32'd1);
            check("row_latency", cyc, RL + 2);
            check("row_sum", {14'd0, o_sum}, exp[r]);
            check("row_idx", {30'd0, o_row_idx}, r);
            if (r == bp_row) begin
                i_sum_ready = 1'b0;
                hold = pops;
                for (int k = 0; k < 5; k++) begin
                    @(negedge i_clk);
                    i_start = (k == 1);
                    check("bp_valid", {31'd0, o_sum_valid}, 32'd1);
                    check("bp_sum", {14'd0, o_sum}, exp[r]);
                    check("bp_no_pop", {31'd0, o_pop_cmd}, 32'd0);
                    check("bp_pop_count", pops, hold);
                end
                i_start     = 1'b0;
                i_sum_ready = 1'b1;
            end
            @(negedge i_clk);
            check("valid_drop", {31'd0, o_sum_valid}, 32'd0);
            if (r < NR - 1) begin
                check("next_pop", {31'd0, o_pop_cmd}, 32'd1);
                check("idx_inc", {30'd0, o_row_idx}, r + 1);
                check("done_early", {31'd0, o_done}, 32'd0);
            end else begin
                check("done_pulse", {31'd0, o_done}, 32'd1);
                check("busy_off", {31'd0, o_busy}, 32'd0);
                check("no_pop_idle", {31'd0, o_pop_cmd}, 32'd0);
                @(negedge i_clk);
                check("done_one_cycle", {31'd0, o_done}, 32'd0);
            end
        end
        check("pop_total", pops - pops0, NR * RL);
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        check("rst_pop", {31'd0, o_pop_cmd}, 32'd0);
        check("rst_valid", {31'd0, o_sum_valid}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_sum", {14'd0, o_sum}, 32'd0);
        check("rst_idx", {30'd0, o_row_idx}, 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Basic drain: LIFO of 1..16 gives 16+15+14+13, 12+..+9, ...
        push_seq_1_16();
        run_rows({32'd10, 32'd26, 32'd42, 32'd58}, -1);

        // Backpressure on row 1 with an ignored start pulse.
        push_seq_1_16();
        run_rows({32'd10, 32'd26, 32'd42, 32'd58}, 1);

        // Largest operands: four 0xFFFF in the first popped row.
        for (int i = 0; i < 12; i++) push(16'h0000);
        for (int i = 0; i < 4; i++) push(16'hFFFF);
        run_rows({32'd0, 32'd0, 32'd0, 32'h0003_FFFC}, -1);

        // Signedness: row {0xFFFF, 1, 0, 0}.
        for (int i = 0; i < 12; i++) push(16'h0000);
        push(16'h0000);
        push(16'h0000);
        push(16'h0001);
        push(16'hFFFF);
        run_rows({32'd0, 32'd0, 32'd0, SGN_EXP}, -1);

        // Reset while popping, then a clean run.
        clear_buf();
        push_seq_1_16();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check("pre_rst_pop", {31'd0, o_pop_cmd}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        check("async_pop", {31'd0, o_pop_cmd}, 32'd0);
        check("async_busy", {31'd0, o_busy}, 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("post_rst_busy", {31'd0, o_busy}, 32'd0);
        check("post_rst_valid", {31'd0, o_sum_valid}, 32'd0);
        check("post_rst_sum", {14'd0, o_sum}, 32'd0);
        check("post_rst_pop", {31'd0, o_pop_cmd}, 32'd0);
        repeat (3) @(negedge i_clk);
        check("idle_stays", {31'd0, o_busy}, 32'd0);
        clear_buf();
        push_seq_1_16();
        run_rows({32'd10, 32'd26, 32'd42, 32'd58}, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
